shift_unit_arbiter: RTL

//   Shares one combinational shifter instance (sll/srl/sra, funct 00/01/11) among NUM_REQ requesters.

---
 rtl/shift_unit_arbiter_if.sv | 27 ++
 rtl/shift_unit_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/shift_unit_arbiter_if.sv
// Handshake and response bundle between the requesters/consumer and the shared
// shift unit arbiter.
interface shift_unit_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [2*NUM_REQ-1:0]  req_funct;
    logic [32*NUM_REQ-1:0] req_a;
    logic [5*NUM_REQ-1:0]  req_n;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_data;
    logic                  rsp_ready;
    logic [15:0]           busy_cnt;

    modport master (
        output req_valid, req_funct, req_a, req_n, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy_cnt
    );

    modport slave (
        input  req_valid, req_funct, req_a, req_n, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy_cnt
    );
endinterface

// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing one combinational sll/srl/sra shifter among
// NUM_REQ requesters, with a single registered response slot.
module shift_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shift_unit_arbiter_if.slave   bus
);
    localparam int              DATA_W    = 32;
    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [15:0]         busy_cnt_q, busy_cnt_d;

    logic [ID_W-1:0]     ptr_eff;
    logic [ID_W-1:0]     grant;
    logic [ID_W:0]       idx_w;
    logic                found;
    logic                slot_free;
    logic                accept;
    logic [NUM_REQ-1:0]  ready_vec;

    logic [1:0]          funct_arr [NUM_REQ];
    logic [DATA_W-1:0]   a_arr     [NUM_REQ];
    logic [4:0]          n_arr     [NUM_REQ];

    function automatic logic [DATA_W-1:0] shift_op(input logic [1:0]        funct,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [4:0]        n);
        logic signed [DATA_W-1:0] a_s;
        a_s = signed'(a);
        case (funct)
            2'b00:   return a << n;
            2'b01:   return a >> n;
            2'b11:   return DATA_W'(a_s >>> n);
            default: return '0;
        endcase
    endfunction

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign funct_arr[gi] = bus.req_funct[2*gi +: 2];
        assign a_arr[gi]     = bus.req_a[32*gi +: 32];
        assign n_arr[gi]     = bus.req_n[5*gi +: 5];
    end

    // Round-robin search from rr_ptr; an out-of-range pointer restarts at 0.
    always_comb begin
        ptr_eff = ({1'b0, rr_ptr_q} < NUM_REQ_W) ? rr_ptr_q : '0;
        found   = 1'b0;
        grant   = '0;
        idx_w   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_w = {1'b0, ptr_eff} + (ID_W+1)'(k);
            if (idx_w >= NUM_REQ_W) begin
                idx_w = idx_w - NUM_REQ_W;
            end
            if (!found && bus.req_valid[idx_w[ID_W-1:0]]) begin
                found = 1'b1;
                grant = idx_w[ID_W-1:0];
            end
        end
    end

    assign slot_free = (state_q == EMPTY) || bus.rsp_ready;
    assign accept    = found && slot_free;

    always_comb begin
        ready_vec = '0;
        if (accept) begin
            ready_vec[grant] = 1'b1;
        end
    end

    assign bus.req_ready = ready_vec & {NUM_REQ{rst_n}};

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        busy_cnt_d = busy_cnt_q;

        if (state_q == EMPTY) begin
            if (accept) state_d = FULL;
        end else begin
            if (bus.rsp_ready) begin
                if (!accept) state_d = EMPTY;
            end else if (busy_cnt_q != 16'hFFFF) begin
                busy_cnt_d = busy_cnt_q + 16'd1;
            end
        end

        if (accept) begin
            rsp_data_d = shift_op(funct_arr[grant], a_arr[grant], n_arr[grant]);
            rsp_id_d   = grant;
            rr_ptr_d   = (grant == LAST_ID) ? '0 : grant + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            rr_ptr_q   <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            busy_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign bus.rsp_valid = (state_q == FULL);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy_cnt  = busy_cnt_q;
endmodule
